// File: rtl/dual_port_ram_resp_pkg.sv
// Shared types for the dual-port RAM responder.
// Provides the data/address widths, the word and address types, and the
// read-pipeline stage payload carried from the sample edge to data_out.
package ram_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned COLL_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] ram_data_t;
  typedef logic [ADDR_WIDTH-1:0] ram_addr_t;
  typedef logic [COLL_WIDTH-1:0] coll_cnt_t;

  // One in-flight read result.
  typedef struct packed {
    logic      valid;
    logic      uninit;
    ram_data_t data;
  } rd_stage_t;

endpackage

// File: rtl/dual_port_ram_resp_if.sv
// Write/read bus between the RAM drivers (master) and the responder (slave).
// Master drives write, wr_address, data_in, read, rd_address; the slave
// returns data_out, data_valid, rd_uninit and coll_count.
interface dual_port_ram_resp_if;
  import ram_pkg::*;

  logic      write;
  ram_addr_t wr_address;
  ram_data_t data_in;
  logic      read;
  ram_addr_t rd_address;
  ram_data_t data_out;
  logic      data_valid;
  logic      rd_uninit;
  coll_cnt_t coll_count;

  modport master (
    output write, wr_address, data_in, read, rd_address,
    input  data_out, data_valid, rd_uninit, coll_count
  );

  modport slave (
    input  write, wr_address, data_in, read, rd_address,
    output data_out, data_valid, rd_uninit, coll_count
  );

endinterface

// File: rtl/dual_port_ram_resp_rd_pipe.sv
// Fixed-latency read result pipeline.
// Ports: clock, reset (sync, active-high), in_stage (result captured at the
// sample edge), out_stage (registered result DEPTH edges later, counting the
// sample edge as the first).
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  rd_stage_t in_stage,
  output rd_stage_t out_stage
);

  localparam int unsigned LAST = DEPTH - 1;

  rd_stage_t stage [DEPTH];
  rd_stage_t src   [DEPTH];

  // Source of each stage: the new capture for stage 0, the previous stage otherwise.
  always_comb begin
    src[0] = in_stage;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      src[i] = stage[i-1];
    end
  end

  // The final stage keeps its data on idle slots so data_out holds its last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LAST; i++) begin
        stage[i] <= src[i];
      end
      stage[LAST].valid  <= src[LAST].valid;
      stage[LAST].uninit <= src[LAST].valid & src[LAST].uninit;
      if (src[LAST].valid) begin
        stage[LAST].data <= src[LAST].data;
      end
    end
  end

  assign out_stage = stage[LAST];

endmodule

// File: rtl/dual_port_ram_resp.sv
// Responder end of the dual-port RAM protocol.
// Ports: clock, reset (sync, active-high), bus (slave modport: write port,
// read port, read-valid, uninitialised-read flag, collision counter).
// Owns the array, the per-word written bitmap, the write-first bypass and
// the saturating same-address collision counter.
module dual_port_ram_resp
  import ram_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  dual_port_ram_resp_if.slave  bus
);

  if (RAM_DEPTH != (1 << ADDR_WIDTH) || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_param
    $error("dual_port_ram_resp: RAM_DEPTH must be 2**ADDR_WIDTH and RD_LATENCY 1..4");
  end

  ram_data_t          mem [RAM_DEPTH];
  logic [RAM_DEPTH-1:0] written;
  coll_cnt_t          coll_count;
  rd_stage_t          in_stage;
  rd_stage_t          out_stage;
  logic               collide;

  assign collide = bus.read & bus.write & (bus.rd_address == bus.wr_address);

  // Array contents survive reset; only the bitmap marks them as stale.
  always_ff @(posedge clock) begin
    if (!reset && bus.write) begin
      mem[bus.wr_address] <= bus.data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      written <= '0;
    end else if (bus.write) begin
      written[bus.wr_address] <= 1'b1;
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      coll_count <= '0;
    end else if (collide && (coll_count != '1)) begin
      coll_count <= coll_count + COLL_WIDTH'(1);
    end
  end

  // Capture at the sample edge: bypass wins, then never-written reads return zero.
  always_comb begin
    in_stage       = '0;
    in_stage.valid = bus.read;
    if (bus.read) begin
      if (collide) begin
        in_stage.data = bus.data_in;
      end else if (!written[bus.rd_address]) begin
        in_stage.uninit = 1'b1;
      end else begin
        in_stage.data = mem[bus.rd_address];
      end
    end
  end

  ram_rd_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_stage  (in_stage),
    .out_stage (out_stage)
  );

  assign bus.data_out   = out_stage.data;
  assign bus.data_valid = out_stage.valid;
  assign bus.rd_uninit  = out_stage.uninit;
  assign bus.coll_count = coll_count;

endmodule

// File: tb/tb_dual_port_ram_resp.sv
// Directed self-checking bench for dual_port_ram_resp.
module tb_dual_port_ram_resp;
  import ram_pkg::*;

  localparam int unsigned LAT = 2;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  dual_port_ram_resp_if bus ();

  dual_port_ram_resp #(
    .RD_LATENCY (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Remaining edges after the sample edge until the result is visible.
  task automatic wait_lat();
    repeat (LAT - 1) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.wr_address = '0;
    bus.rd_address = '0;
    bus.data_in    = '0;
  endtask

  task automatic do_write(input ram_addr_t a, input ram_data_t d);
    bus.write = 1'b1; bus.wr_address = a; bus.data_in = d;
    tick();
    bus.write = 1'b0;
  endtask

  // Issue one read and wait until its result is visible.
  task automatic do_read(input ram_addr_t a);
    bus.read = 1'b1; bus.rd_address = a;
    tick();
    bus.read = 1'b0;
    wait_lat();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_bus();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid", 64'(bus.data_valid), 64'd0);
    check("rst_data",  bus.data_out,        64'd0);
    check("rst_uninit", 64'(bus.rd_uninit), 64'd0);
    check("rst_coll",  64'(bus.coll_count), 64'd0);

    // Never-written location.
    do_read(12'h010);
    check("uninit_valid", 64'(bus.data_valid), 64'd1);
    check("uninit_flag",  64'(bus.rd_uninit),  64'd1);
    check("uninit_data",  bus.data_out,        64'd0);
    tick();
    check("idle_valid",  64'(bus.data_valid), 64'd0);
    check("idle_uninit", 64'(bus.rd_uninit),  64'd0);

    // Write then read.
    do_write(12'h010, 64'hDEAD_BEEF_0000_0001);
    bus.read = 1'b1; bus.rd_address = 12'h010;
    tick();
    bus.read = 1'b0;
    check("lat_not_early", 64'(bus.data_valid), 64'd0);
    wait_lat();
    check("wr_rd_valid",  64'(bus.data_valid), 64'd1);
    check("wr_rd_data",   bus.data_out,        64'hDEAD_BEEF_0000_0001);
    check("wr_rd_uninit", 64'(bus.rd_uninit),  64'd0);
    tick();
    check("hold_valid", 64'(bus.data_valid), 64'd0);
    check("hold_data",  bus.data_out,        64'hDEAD_BEEF_0000_0001);

    // Same-edge write/read to one address: bypass and collision.
    bus.write = 1'b1; bus.wr_address = 12'h020; bus.data_in = 64'hA5A5;
    bus.read  = 1'b1; bus.rd_address = 12'h020;
    tick();
    idle_bus();
    check("coll_inc", 64'(bus.coll_count), 64'd1);
    wait_lat();
    check("byp_valid",  64'(bus.data_valid), 64'd1);
    check("byp_data",   bus.data_out,        64'hA5A5);
    check("byp_uninit", 64'(bus.rd_uninit),  64'd0);

    // Same edge, different addresses: no collision.
    bus.write = 1'b1; bus.wr_address = 12'h040; bus.data_in = 64'h4444;
    bus.read  = 1'b1; bus.rd_address = 12'h010;
    tick();
    idle_bus();
    wait_lat();
    check("nocoll_data", bus.data_out,        64'hDEAD_BEEF_0000_0001);
    check("nocoll_cnt",  64'(bus.coll_count), 64'd1);

    // Snapshot: a later write does not alter the in-flight read.
    do_write(12'h030, 64'h1);
    bus.read = 1'b1; bus.rd_address = 12'h030;
    tick();
    bus.read = 1'b0;
    bus.write = 1'b1; bus.wr_address = 12'h030; bus.data_in = 64'h2;
    wait_lat();
    bus.write = 1'b0;
    check("snap_data",  bus.data_out,        64'h1);
    check("snap_valid", 64'(bus.data_valid), 64'd1);
    do_read(12'h030);
    check("snap_after", bus.data_out, 64'h2);
    do_read(12'h040);
    check("diff_addr_wr", bus.data_out, 64'h4444);

    // Fill 0..15 with data=addr, then stream 16 back-to-back reads.
    for (int i = 0; i < 16; i++) do_write(ram_addr_t'(i), ram_data_t'(i));
    begin
      int got;
      int expect_idx;
      got = 0;
      expect_idx = 0;
      for (int i = 0; i < 16 + int'(LAT) - 1; i++) begin
        bus.read = (i < 16);
        bus.rd_address = ram_addr_t'(i);
        tick();
        if (bus.data_valid) begin
          check("stream_data", bus.data_out, 64'(expect_idx));
          got++;
          expect_idx++;
        end
      end
      bus.read = 1'b0;
      tick();
      check("stream_tail", 64'(bus.data_valid), 64'd0);
      check("stream_count", 64'(got), 64'd16);
    end

    // Reset with a read in flight drops it and forgets all writes.
    bus.read = 1'b1; bus.rd_address = 12'h010;
    tick();
    bus.read = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_valid", 64'(bus.data_valid), 64'd0);
    check("rst2_data",  bus.data_out,        64'd0);
    check("rst2_coll",  64'(bus.coll_count), 64'd0);
    begin
      int stray;
      stray = 0;
      repeat (LAT + 1) begin
        tick();
        if (bus.data_valid) stray++;
      end
      check("rst2_no_valid", 64'(stray), 64'd0);
    end
    do_read(12'h010);
    check("rst2_rd_valid",  64'(bus.data_valid), 64'd1);
    check("rst2_rd_uninit", 64'(bus.rd_uninit),  64'd1);
    check("rst2_rd_data",   bus.data_out,        64'd0);
    do_read(12'h005);
    check("rst2_rd5_uninit", 64'(bus.rd_uninit), 64'd1);
    check("rst2_rd5_data",   bus.data_out,       64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
